// File: rtl/valvula_pkg.sv
// Shared types for the multi-channel valve controller.
// Per-channel state encoding and a counter-width helper.
package valvula_pkg;

  typedef enum logic [1:0] {
    FECHADA   = 2'd0,
    ABERTA    = 2'd1,
    BLOQUEADA = 2'd2
  } estado_t;

  function automatic int largura(input int valor);
    return (valor <= 1) ? 1 : $clog2(valor);
  endfunction

endpackage

// File: rtl/valvula_canal.sv
// One valve channel: state FSM, anti-chatter hold counter
// and auto-mode open timer that latches a fault.
module valvula_canal
  import valvula_pkg::*;
#(
  parameter int MIN_HOLD   = 16,
  parameter int MAX_ABERTA = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic manual,
  input  logic abre_auto,
  input  logic fecha_auto,
  input  logic abre_manual,
  output logic abre_valvula,
  output logic falha
);

  localparam int HW = largura(MIN_HOLD + 1);
  localparam int TW = largura(MAX_ABERTA + 1);
  localparam logic [HW-1:0] HOLD_INI = HW'(MIN_HOLD - 1);
  localparam logic [TW-1:0] T_LIM = TW'(MAX_ABERTA - 1);
  localparam logic [TW-1:0] T_SAT = TW'(MAX_ABERTA);
  localparam bit TIMEOUT_ON = (MAX_ABERTA > 0);

  estado_t estado_q, estado_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] timer_q, timer_d;
  logic quer_abrir;
  logic livre;
  logic expira;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= FECHADA;
      hold_q   <= '0;
      timer_q  <= '0;
    end else begin
      estado_q <= estado_d;
      hold_q   <= hold_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    quer_abrir = (estado_q == ABERTA);
    if (manual)          quer_abrir = abre_manual;
    else if (abre_auto)  quer_abrir = 1'b1;
    else if (fecha_auto) quer_abrir = 1'b0;

    livre  = (hold_q == '0);
    expira = TIMEOUT_ON && (estado_q == ABERTA)
             && !manual && (timer_q == T_LIM);

    estado_d = estado_q;
    case (estado_q)
      FECHADA:
        if (livre && quer_abrir) estado_d = ABERTA;
      ABERTA:
        if (expira)                   estado_d = BLOQUEADA;
        else if (livre && !quer_abrir) estado_d = FECHADA;
      BLOQUEADA:
        if (manual || (fecha_auto && !abre_auto))
          estado_d = FECHADA;
      default: estado_d = FECHADA;
    endcase

    hold_d = hold_q;
    if (estado_d != estado_q) hold_d = HOLD_INI;
    else if (!livre)          hold_d = hold_q - 1'b1;

    // Timer only runs across consecutive auto-mode open cycles
    timer_d = '0;
    if (estado_q == ABERTA && estado_d == ABERTA && !manual)
      timer_d = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
  end

  always_comb begin
    abre_valvula = (estado_q == ABERTA);
    falha        = (estado_q == BLOQUEADA);
  end

endmodule

// File: rtl/valvula_multicanal.sv
// N independent valve channels; bit i of every vector
// belongs to channel i.
module valvula_multicanal
  import valvula_pkg::*;
#(
  parameter int N_CANAIS   = 4,
  parameter int MIN_HOLD   = 16,
  parameter int MAX_ABERTA = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_CANAIS-1:0] manual,
  input  logic [N_CANAIS-1:0] abre_auto,
  input  logic [N_CANAIS-1:0] fecha_auto,
  input  logic [N_CANAIS-1:0] abre_manual,
  output logic [N_CANAIS-1:0] abre_valvula,
  output logic [N_CANAIS-1:0] falha
);

  for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
    valvula_canal #(
      .MIN_HOLD  (MIN_HOLD),
      .MAX_ABERTA(MAX_ABERTA)
    ) u_canal (
      .clock       (clock),
      .reset       (reset),
      .manual      (manual[i]),
      .abre_auto   (abre_auto[i]),
      .fecha_auto  (fecha_auto[i]),
      .abre_manual (abre_manual[i]),
      .abre_valvula(abre_valvula[i]),
      .falha       (falha[i])
    );
  end

endmodule

// File: tb/tb_valvula_multicanal.sv
// Directed and random checks of valvula_multicanal against
// a cycle-count model of hold, timeout and fault rules.
module tb_valvula_multicanal;

  localparam int N  = 4;
  localparam int MH = 4;
  localparam int MX = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] manual, abre_auto, fecha_auto, abre_manual;
  logic [N-1:0] abre_valvula, falha;

  int compared = 0;
  int fails    = 0;

  bit m_open [N];
  bit m_fault[N];
  int m_age  [N];
  int m_run  [N];

  valvula_multicanal #(
    .N_CANAIS  (N),
    .MIN_HOLD  (MH),
    .MAX_ABERTA(MX)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .manual      (manual),
    .abre_auto   (abre_auto),
    .fecha_auto  (fecha_auto),
    .abre_manual (abre_manual),
    .abre_valvula(abre_valvula),
    .falha       (falha)
  );

  always #5 clock = ~clock;

  function automatic logic [N-1:0] exp_open();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_open[i];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_fault();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_fault[i];
    return v;
  endfunction

  // age = cycles the current state has been visible
  // run = preceding consecutive auto-mode open cycles
  task automatic model_edge();
    bit nopen, nfault, want, changed;
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_open[i]  = 1'b0;
        m_fault[i] = 1'b0;
        m_age[i]   = MH;
        m_run[i]   = 0;
      end else begin
        nopen   = m_open[i];
        nfault  = m_fault[i];
        changed = 1'b0;
        if (m_fault[i]) begin
          if (manual[i] || (fecha_auto[i] && !abre_auto[i])) begin
            nfault  = 1'b0;
            changed = 1'b1;
          end
        end else if (m_open[i] && !manual[i] && MX > 0
                     && m_run[i] + 1 >= MX) begin
          nopen   = 1'b0;
          nfault  = 1'b1;
          changed = 1'b1;
        end else begin
          if (manual[i])          want = abre_manual[i];
          else if (abre_auto[i])  want = 1'b1;
          else if (fecha_auto[i]) want = 1'b0;
          else                    want = m_open[i];
          if (want != m_open[i] && m_age[i] >= MH) begin
            nopen   = want;
            changed = 1'b1;
          end
        end
        m_run[i] = (m_open[i] && nopen && !manual[i]) ? m_run[i] + 1 : 0;
        if (changed)          m_age[i] = 1;
        else if (m_age[i] < MH) m_age[i] = m_age[i] + 1;
        m_open[i]  = nopen;
        m_fault[i] = nfault;
      end
    end
  endtask

  task automatic tick(input string tag);
    logic [N-1:0] eo, ef;
    @(posedge clock);
    model_edge();
    #1;
    eo = exp_open();
    ef = exp_fault();
    compared++;
    assert (abre_valvula === eo) else begin
      fails++;
      $error("FAIL %s abre_valvula observed=%b expected=%b", tag, abre_valvula, eo);
    end
    compared++;
    assert (falha === ef) else begin
      fails++;
      $error("FAIL %s falha observed=%b expected=%b", tag, falha, ef);
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs,
                     input logic [N-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  initial begin
    int changes;
    logic prev;

    reset       = 1'b1;
    manual      = 'x;
    abre_auto   = 'x;
    fecha_auto  = 'x;
    abre_manual = 'x;
    tick("reset0");
    tick("reset1");
    reset       = 1'b0;
    manual      = '0;
    abre_auto   = '0;
    fecha_auto  = '0;
    abre_manual = '0;
    tick("idle");
    chk("reset_valve", abre_valvula, 4'b0000);
    chk("reset_falha", falha, 4'b0000);

    abre_auto[0] = 1'b1;
    tick("ch0_open");
    chk("ch0_open_lat1", abre_valvula, 4'b0001);
    abre_auto[0]  = 1'b0;
    fecha_auto[0] = 1'b1;
    for (int k = 0; k < 3; k++) tick("ch0_hold");
    chk("ch0_still_open", {3'b0, abre_valvula[0]}, 4'b0001);
    tick("ch0_close");
    chk("ch0_closed", {3'b0, abre_valvula[0]}, 4'b0000);
    fecha_auto[0] = 1'b0;

    abre_auto[1]  = 1'b1;
    fecha_auto[1] = 1'b1;
    tick("ch1_both");
    chk("ch1_abre_wins", abre_valvula, 4'b0010);
    abre_auto[1] = 1'b0;
    for (int k = 0; k < 4; k++) tick("ch1_close");
    chk("ch1_closed", abre_valvula, 4'b0000);
    fecha_auto[1] = 1'b0;

    abre_auto[2] = 1'b1;
    tick("ch2_open");
    for (int k = 0; k < 7; k++) tick("ch2_run");
    chk("ch2_open_8", {3'b0, abre_valvula[2]}, 4'b0001);
    tick("ch2_timeout");
    chk("ch2_valve_off", {3'b0, abre_valvula[2]}, 4'b0000);
    chk("ch2_fault_on", {3'b0, falha[2]}, 4'b0001);
    tick("ch2_abre_only");
    tick("ch2_abre_only");
    chk("ch2_fault_kept", {3'b0, falha[2]}, 4'b0001);
    abre_auto[2]  = 1'b0;
    fecha_auto[2] = 1'b1;
    tick("ch2_clear");
    chk("ch2_fault_off", {3'b0, falha[2]}, 4'b0000);
    chk("ch2_closed", {3'b0, abre_valvula[2]}, 4'b0000);
    fecha_auto[2] = 1'b0;

    manual[3] = 1'b1;
    changes   = 0;
    prev      = abre_valvula[3];
    for (int k = 0; k < 16; k++) begin
      abre_manual[3] = ~abre_manual[3];
      tick("ch3_toggle");
      if (abre_valvula[3] !== prev) changes++;
      prev = abre_valvula[3];
    end
    chk("ch3_chatter", {3'b0, (changes <= 4)}, 4'b0001);
    abre_manual[3] = 1'b1;
    for (int k = 0; k < 20; k++) tick("ch3_manual_open");
    chk("ch3_no_fault", {3'b0, falha[3]}, 4'b0000);
    chk("ch3_open", {3'b0, abre_valvula[3]}, 4'b0001);

    manual       = '0;
    abre_manual  = '0;
    fecha_auto   = 4'b1000;
    for (int k = 0; k < 4; k++) tick("ch3_close");
    fecha_auto   = '0;
    abre_auto[0] = 1'b1;
    tick("ch0_reopen");
    abre_auto[0] = 1'b0;
    tick("ch0_midhold");
    reset = 1'b1;
    tick("mid_reset");
    chk("mid_reset_valve", abre_valvula, 4'b0000);
    chk("mid_reset_falha", falha, 4'b0000);
    reset        = 1'b0;
    abre_auto[0] = 1'b1;
    tick("post_reset");
    chk("post_reset_accept", abre_valvula, 4'b0001);
    abre_auto[0] = 1'b0;

    for (int k = 0; k < 800; k++) begin
      reset = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) manual[i] = ~manual[i];
      for (int i = 0; i < N; i++) begin
        abre_auto[i]   = ($urandom_range(0, 9) < 4);
        fecha_auto[i]  = ($urandom_range(0, 9) < 2);
        abre_manual[i] = ($urandom_range(0, 9) < 6);
      end
      tick("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end

endmodule
